// File: rtl/clk_switch_ctrl.sv
// Switch sequencer for a glitch-free two-clock mux: handshake-driven source
// selection, heartbeat liveness per source clock, and optional failover.
module clk_switch_ctrl #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  input  logic fail_en_i,
  input  logic hb_clk1_i,
  input  logic hb_clk2_i,
  output logic sel_clk1_o,
  output logic cur_clk1_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic alive_clk1_o,
  output logic alive_clk2_o
);

  localparam logic [1:0] ST_STABLE = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SET_MAX = CNT_W'(SETTLE_CYC - 1);

  // Bit 0 tracks clk1, bit 1 tracks clk2.
  logic [1:0] hb_w;
  logic [1:0] alive_w;
  assign hb_w = {hb_clk2_i, hb_clk1_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hb
      logic [2:0]       sync_q;
      logic [CNT_W-1:0] wd_q;
      logic [CNT_W-1:0] wd_d;
      logic             alive_q;
      logic             alive_d;
      logic             edge_w;

      assign edge_w = sync_q[1] ^ sync_q[2];

      always_comb begin
        wd_d    = wd_q;
        alive_d = alive_q;
        if (edge_w) begin
          wd_d    = '0;
          alive_d = 1'b1;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
          if (wd_d == WD_MAX) alive_d = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q  <= '0;
          wd_q    <= WD_MAX;
          alive_q <= 1'b0;
        end else begin
          sync_q  <= {sync_q[1:0], hb_w[gi]};
          wd_q    <= wd_d;
          alive_q <= alive_d;
        end
      end

      assign alive_w[gi] = alive_q;
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic             target_q, target_d;
  logic             sel_q, sel_d;
  logic             cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;

  logic accept_w;
  logic failover_w;
  logic tgt_alive_w;
  logic act_alive_w;
  logic oth_alive_w;

  assign tgt_alive_w = target_q ? alive_w[0] : alive_w[1];
  assign act_alive_w = cur_q ? alive_w[0] : alive_w[1];
  assign oth_alive_w = cur_q ? alive_w[1] : alive_w[0];
  // rdy_q is only ever set while STABLE, so it doubles as the "may act" qualifier.
  assign accept_w    = rdy_q & req_valid_i;
  assign failover_w  = rdy_q & fail_en_i & ~act_alive_w & oth_alive_w;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sel_d    = sel_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (accept_w) begin
          target_d = req_sel_i;
          if (req_sel_i == cur_q) done_d = 1'b1;
          else                    state_d = ST_CHECK;
        end else if (failover_w) begin
          target_d = ~cur_q;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (tgt_alive_w) begin
          sel_d   = target_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_STABLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SET_MAX) begin
          done_d  = 1'b1;
          cur_d   = sel_q;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_STABLE;
    endcase
    // Hold off one extra cycle after a completed switch so done is seen first.
    rdy_d = (state_d == ST_STABLE) && (state_q != ST_SETTLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STABLE;
      target_q <= 1'b1;
      sel_q    <= 1'b1;
      cur_q    <= 1'b1;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_q    <= rdy_d;
    end
  end

  assign req_ready_o  = rdy_q;
  assign sel_clk1_o   = sel_q;
  assign cur_clk1_o   = cur_q;
  assign busy_o       = (state_q == ST_CHECK) || (state_q == ST_SETTLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign alive_clk1_o = alive_w[0];
  assign alive_clk2_o = alive_w[1];

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: scoreboarded done/err events against a timing
// model of liveness windows and switch latencies, plus directed scenarios.
module tb_clk_switch_ctrl;

  localparam int SETTLE = 16;
  localparam int TMO    = 64;
  localparam int NONE   = -100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic fail_en = 1'b0;
  logic hb1 = 1'b0;
  logic hb2 = 1'b0;
  logic req_ready, sel_clk1, cur_clk1, busy, done, err, alive1, alive2;

  clk_switch_ctrl #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_sel_i(req_sel), .req_ready_o(req_ready),
    .fail_en_i(fail_en), .hb_clk1_i(hb1), .hb_clk2_i(hb2),
    .sel_clk1_o(sel_clk1), .cur_clk1_o(cur_clk1), .busy_o(busy),
    .done_o(done), .err_o(err),
    .alive_clk1_o(alive1), .alive_clk2_o(alive2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Heartbeat sources: toggle times are recorded as the cycle they are driven in.
  bit run1 = 1'b1;
  bit run2 = 1'b1;
  int per1 = 5;
  int per2 = 6;
  int hcnt1 = 4;
  int hcnt2 = 5;
  int k1_new = NONE, k1_old = NONE, k2_new = NONE, k2_old = NONE;

  always @(negedge clk) begin
    if (!rst && run1) begin
      if (hcnt1 >= per1 - 1) begin
        hcnt1 = 0; hb1 = ~hb1; k1_old = k1_new; k1_new = cyc;
      end else hcnt1++;
    end
    if (!rst && run2) begin
      if (hcnt2 >= per2 - 1) begin
        hcnt2 = 0; hb2 = ~hb2; k2_old = k2_new; k2_new = cyc;
      end else hcnt2++;
    end
  end

  // A clock is alive in cycle n if some heartbeat toggle landed between
  // TMO+1 and 3 cycles earlier (3 = synchroniser plus registered flag).
  function automatic bit in_win(int d);
    return (d >= 3) && (d <= TMO + 1);
  endfunction

  function automatic bit model_alive(int idx, int n);
    if (idx == 0) return in_win(n - k1_new) || in_win(n - k1_old);
    return in_win(n - k2_new) || in_win(n - k2_old);
  endfunction

  typedef struct {
    bit is_err;
    int at;
    bit cur;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   m_cur = 1'b1;
  bit   rel_valid = 1'b0;
  int   rel_cyc = 0;

  // Event monitor: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_event: done=%0d err=%0d with nothing expected (cycle %0d)",
                 done, err, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("event_kind_err", {31'b0, err}, {31'b0, mon_e.is_err});
        check("event_cycle", cyc, mon_e.at);
        check("event_cur", {31'b0, cur_clk1}, {31'b0, mon_e.cur});
        check("event_sel", {31'b0, sel_clk1}, {31'b0, mon_e.cur});
        check("done_err_excl", {31'b0, done & err}, 0);
      end
    end
  end

  // Liveness monitor, held off briefly after each reset release.
  always @(negedge clk) begin
    if (!rst && rel_valid && (cyc >= rel_cyc + 10)) begin
      check("alive_clk1", {31'b0, alive1}, {31'b0, model_alive(0, cyc)});
      check("alive_clk2", {31'b0, alive2}, {31'b0, model_alive(1, cyc)});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_req(input bit s, output int t);
    int w;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", {31'b0, req_ready}, 1);
    req_valid = 1'b1;
    req_sel   = s;
    t = cyc;
    if (s == m_cur) begin
      sb.push_back('{is_err: 1'b0, at: t + 1, cur: m_cur});
    end else if (model_alive(s ? 0 : 1, t + 1)) begin
      sb.push_back('{is_err: 1'b0, at: t + 2 + SETTLE, cur: s});
      m_cur = s;
    end else begin
      sb.push_back('{is_err: 1'b1, at: t + 2, cur: m_cur});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "time limit reached");
  end

  initial begin
    int t;
    int n;
    bit found;

    // Reset state
    wait_cyc(3);
    check("rst_sel", {31'b0, sel_clk1}, 1);
    check("rst_cur", {31'b0, cur_clk1}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_ready", {31'b0, req_ready}, 0);
    check("rst_alive1", {31'b0, alive1}, 0);
    check("rst_alive2", {31'b0, alive2}, 0);
    rst = 1'b0;
    rel_cyc = cyc;
    rel_valid = 1'b1;
    @(negedge clk);
    check("ready_after_release", {31'b0, req_ready}, 1);
    wait_cyc(7);
    check("alive1_within_8", {31'b0, alive1}, 1);
    check("alive2_within_8", {31'b0, alive2}, 1);
    wait_cyc(5);

    // Switch to clk2 with exact timing
    do_req(1'b0, t);
    check("sw_ready_t1", {31'b0, req_ready}, 0);
    check("sw_sel_t1", {31'b0, sel_clk1}, 1);
    check("sw_busy_t1", {31'b0, busy}, 1);
    @(negedge clk);
    check("sw_sel_t2", {31'b0, sel_clk1}, 0);
    while (cyc < t + 19) begin
      check("sw_ready_low", {31'b0, req_ready}, 0);
      @(negedge clk);
    end
    check("sw_ready_back", {31'b0, req_ready}, 1);
    check("sw_cur", {31'b0, cur_clk1}, 0);
    do_req(1'b1, t);
    wait_cyc(20);

    // Request to a dead clk2
    run2 = 1'b0;
    wait_cyc(TMO + 4);
    check("dead_alive2", {31'b0, alive2}, 0);
    do_req(1'b0, t);
    check("dead_sel_t1", {31'b0, sel_clk1}, 1);
    @(negedge clk);
    check("dead_sel_t2", {31'b0, sel_clk1}, 1);
    @(negedge clk);
    check("dead_sel_t3", {31'b0, sel_clk1}, 1);
    run2 = 1'b1;
    wait_cyc(10);

    // No-op request to the current clock
    do_req(1'b1, t);
    check("noop_sel", {31'b0, sel_clk1}, 1);
    check("noop_err", {31'b0, err}, 0);
    wait_cyc(3);
    check("noop_sel_later", {31'b0, sel_clk1}, 1);

    // Failover from a stopped clk1
    fail_en = 1'b1;
    run1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!model_alive(0, cyc)) begin
        found = 1'b1;
        break;
      end
    end
    check("fo_model_found", {31'b0, found}, 1);
    n = cyc;
    sb.push_back('{is_err: 1'b0, at: n + 2 + SETTLE, cur: 1'b0});
    m_cur = 1'b0;
    check("fo_sel_n", {31'b0, sel_clk1}, 1);
    @(negedge clk);
    check("fo_sel_n1", {31'b0, sel_clk1}, 1);
    @(negedge clk);
    check("fo_sel_n2", {31'b0, sel_clk1}, 0);
    check("fo_busy_n2", {31'b0, busy}, 1);
    while (cyc < n + 22) @(negedge clk);
    check("fo_cur", {31'b0, cur_clk1}, 0);

    // Same loss of the active clock without failover enabled
    fail_en = 1'b0;
    run1 = 1'b1;
    wait_cyc(10);
    run2 = 1'b0;
    wait_cyc(TMO + 40);
    check("nofo_sel", {31'b0, sel_clk1}, 0);
    check("nofo_cur", {31'b0, cur_clk1}, 0);
    check("nofo_busy", {31'b0, busy}, 0);
    run2 = 1'b1;
    wait_cyc(10);

    // Randomised requests with heartbeats starting and stopping
    for (int it = 0; it < 40; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 8) begin
        run1 = ~run1;
        wait_cyc(int'($urandom_range(0, 80)));
      end else if (r == 9) begin
        run2 = ~run2;
        wait_cyc(int'($urandom_range(0, 80)));
      end else begin
        do_req(1'($urandom_range(0, 1)), t);
      end
      wait_cyc(int'($urandom_range(0, 4)));
    end
    run1 = 1'b1;
    run2 = 1'b1;
    wait_cyc(30);
    do_req(1'b1, t);
    wait_cyc(25);

    // Reset in the middle of a settle window
    do_req(1'b0, t);
    while (cyc < t + 7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_sel", {31'b0, sel_clk1}, 1);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_done", {31'b0, done}, 0);
    check("mid_rst_ready", {31'b0, req_ready}, 0);
    check("mid_rst_cur", {31'b0, cur_clk1}, 1);
    sb.delete();
    m_cur = 1'b1;
    k1_new = NONE; k1_old = NONE; k2_new = NONE; k2_old = NONE;
    rel_valid = 1'b0;
    wait_cyc(3);
    check("mid_rst_hold_sel", {31'b0, sel_clk1}, 1);
    rst = 1'b0;
    rel_cyc = cyc;
    rel_valid = 1'b1;
    wait_cyc(12);
    check("post_rst_cur", {31'b0, cur_clk1}, 1);
    do_req(1'b0, t);
    wait_cyc(SETTLE + 10);
    check("post_rst_cur_final", {31'b0, cur_clk1}, 0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
